// File: rtl/ifu_fetch.sv
// ifu_fetch: multi-cycle instruction fetch stage.
// Issues word fetches over a req/gnt channel and collects in-order rvalid
// responses into a small instruction buffer. The buffer feeds decode over a
// valid/ready handshake. Redirects flush the buffer, and responses that are
// still in flight at that point are discarded as wrong-path.
// Optional feature macro: IFU_MISALIGN_CHK_EN. When it is defined, a
// misaligned redirect raises o_misalign and halts fetch until the next
// aligned redirect.
module ifu_fetch #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RST_PC     = 32'h8000_0000,
  parameter int unsigned       FIFO_DEPTH = 2,
  parameter int unsigned       MAX_OST    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_redir_valid,
  input  logic [ADDR_W-1:0] i_redir_pc,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [31:0]       i_imem_rdata,
  output logic              o_ins_valid,
  output logic [31:0]       o_ins,
  output logic [ADDR_W-1:0] o_ins_pc,
  input  logic              i_ins_ready
`ifdef IFU_MISALIGN_CHK_EN
  ,
  output logic              o_misalign
`endif
);

  localparam int FD     = int'(FIFO_DEPTH);
  localparam int MO     = int'(MAX_OST);
  localparam int FPTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int OST_W  = $clog2(MAX_OST + 1);
  localparam int TPTR_W = (MAX_OST > 1) ? $clog2(MAX_OST) : 1;

`ifdef IFU_MISALIGN_CHK_EN
  typedef enum logic [1:0] {S_BOOT = 2'd0, S_FETCH = 2'd1, S_HALT = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_BOOT = 2'd0, S_FETCH = 2'd1} state_e;
`endif

  // One buffered instruction together with the pc it was fetched from.
  typedef struct packed {
    logic [31:0]       ins;
    logic [ADDR_W-1:0] pc;
  } fetch_ent_t;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [OST_W-1:0]    r_ost;
  logic [OST_W-1:0]    r_drop;
  logic [OST_W-1:0]    w_ost_nxt;

  logic [ADDR_W-1:0]   r_tag [MAX_OST];
  logic [TPTR_W-1:0]   r_tag_wp;
  logic [TPTR_W-1:0]   r_tag_rp;

  fetch_ent_t          r_fifo [FIFO_DEPTH];
  logic [FPTR_W-1:0]   r_fwp;
  logic [FPTR_W-1:0]   r_frp;
  logic [CNT_W-1:0]    r_fcnt;

  logic                w_credit;
  logic                w_grant;
  logic                w_resp;
  logic                w_push;
  logic                w_pop;
  logic [ADDR_W-1:0]   w_redir_tgt;
  fetch_ent_t          w_push_ent;

`ifdef IFU_MISALIGN_CHK_EN
  logic                r_misalign;
  logic                w_misal;
  assign w_misal    = (i_redir_pc[1:0] != 2'b00);
  assign o_misalign = r_misalign;
`endif

  // Fetch addresses are always word aligned; the low bits of a redirect are
  // dropped here, and in the checked build a nonzero value halts fetch.
  assign w_redir_tgt = i_redir_pc & ~ADDR_W'(3);

  // A request may only go out if there is room for its response in the
  // buffer, counting every response still in flight. This is why rvalid
  // never needs back-pressure.
  assign w_credit = (int'(r_ost) < MO) && ((int'(r_ost) + int'(r_fcnt)) < FD);

  assign w_grant   = o_imem_req & i_imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp    = i_imem_rvalid & (r_ost != '0);
  assign w_push    = w_resp & ~i_redir_valid & (r_drop == '0);
  assign w_pop     = o_ins_valid & i_ins_ready;
  assign w_ost_nxt = r_ost + OST_W'(w_grant) - OST_W'(w_resp);

  assign w_push_ent.ins = i_imem_rdata;
  assign w_push_ent.pc  = r_tag[r_tag_rp];

  assign o_imem_addr = r_pc;
  assign o_ins_valid = (r_fcnt != '0);
  assign o_ins       = r_fifo[r_frp].ins;
  assign o_ins_pc    = r_fifo[r_frp].pc;

  function automatic logic [TPTR_W-1:0] tag_inc(input logic [TPTR_W-1:0] p);
    return (int'(p) == MO - 1) ? '0 : p + 1'b1;
  endfunction

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_BOOT;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and request generation.
  always_comb begin
    w_state_nxt = r_state;
    o_imem_req  = 1'b0;
    case (r_state)
      S_BOOT:  w_state_nxt = S_FETCH;
      S_FETCH: o_imem_req  = w_credit;
`ifdef IFU_MISALIGN_CHK_EN
      S_HALT:  o_imem_req  = 1'b0;
`endif
      default: w_state_nxt = S_BOOT;
    endcase
`ifdef IFU_MISALIGN_CHK_EN
    // Every redirect decides halt vs. fetch on its own alignment alone.
    if (i_redir_valid) w_state_nxt = w_misal ? S_HALT : S_FETCH;
`endif
  end

  // Fetch pc: a redirect beats the sequential increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)              r_pc <= RST_PC;
    else if (i_redir_valid) r_pc <= w_redir_tgt;
    else if (w_grant)       r_pc <= r_pc + ADDR_W'(4);
  end

  // Outstanding-request and wrong-path drop counters. On a redirect every
  // request still in flight (including one granted this cycle) becomes
  // wrong-path, so the drop count is simply the next outstanding count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ost  <= '0;
      r_drop <= '0;
    end else begin
      r_ost <= w_ost_nxt;
      if (i_redir_valid)                r_drop <= w_ost_nxt;
      else if (w_resp && r_drop != '0)  r_drop <= r_drop - 1'b1;
    end
  end

  // Tag queue pointers: issued pcs in grant order, popped by each response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tag_wp <= '0;
      r_tag_rp <= '0;
    end else begin
      if (w_grant) r_tag_wp <= tag_inc(r_tag_wp);
      if (w_resp)  r_tag_rp <= tag_inc(r_tag_rp);
    end
  end

  // Tag queue storage; it never overflows because ost is capped at MAX_OST.
  always_ff @(posedge i_clk) begin
    if (w_grant) r_tag[r_tag_wp] <= r_pc;
  end

  // Instruction buffer. A redirect empties it; a decode transfer in the same
  // cycle has already taken the head, so nothing extra is needed for it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fwp  <= '0;
      r_frp  <= '0;
      r_fcnt <= '0;
      for (int i = 0; i < FD; i++) r_fifo[i] <= '0;
    end else if (i_redir_valid) begin
      r_fwp  <= '0;
      r_frp  <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_fwp] <= w_push_ent;
        r_fwp         <= r_fwp + 1'b1;
      end
      if (w_pop) r_frp <= r_frp + 1'b1;
      r_fcnt <= r_fcnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

`ifdef IFU_MISALIGN_CHK_EN
  // Sticky misalign flag, rewritten by every redirect.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)              r_misalign <= 1'b0;
    else if (i_redir_valid) r_misalign <= w_misal;
  end
`endif

`ifndef SYNTHESIS
  // Memory must never answer a request that was not issued.
  always_ff @(posedge i_clk) begin
    if (!i_rst) assert (!(i_imem_rvalid && (r_ost == '0)));
  end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed bench for ifu_fetch. The memory model answers each
// grant with addr ^ KEY after a programmable latency. The reference model
// tracks program order: which pc decode must see next and which address the
// next grant must carry. It checks every transfer and every grant.
// Two instances are used: the default geometry, plus a 4-entry-buffer one,
// because a redirect that coincides with grant, rvalid and a transfer cannot
// arise with the default credit limits.
module tb_ifu_fetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] KEY    = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0;
  logic gnt_en = 1'b0;
  logic ready = 1'b0;
  logic redir_v = 1'b0;
  logic [31:0] redir_pc = '0;
  logic mem_rv = 1'b0;
  logic [31:0] mem_rd = '0;

  logic a_req, a_val, b_req, b_val, a_gnt, b_gnt, a_rv, b_rv;
  logic [31:0] a_addr, a_ins, a_pc, b_addr, b_ins, b_pc;
  logic w_req, w_val;
  logic [31:0] w_addr, w_ins, w_pc;
`ifdef IFU_MISALIGN_CHK_EN
  logic a_mis, b_mis, w_mis;
`endif

  always #5 clk = ~clk;

  assign a_gnt  = !sel && gnt_en;
  assign b_gnt  = sel && gnt_en;
  assign a_rv   = !sel && mem_rv;
  assign b_rv   = sel && mem_rv;
  assign w_req  = sel ? b_req  : a_req;
  assign w_val  = sel ? b_val  : a_val;
  assign w_addr = sel ? b_addr : a_addr;
  assign w_ins  = sel ? b_ins  : a_ins;
  assign w_pc   = sel ? b_pc   : a_pc;
`ifdef IFU_MISALIGN_CHK_EN
  assign w_mis  = sel ? b_mis  : a_mis;
`endif

  ifu_fetch u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_redir_valid(redir_v), .i_redir_pc(redir_pc),
    .o_imem_req(a_req), .o_imem_addr(a_addr), .i_imem_gnt(a_gnt),
    .i_imem_rvalid(a_rv), .i_imem_rdata(mem_rd),
    .o_ins_valid(a_val), .o_ins(a_ins), .o_ins_pc(a_pc), .i_ins_ready(ready)
`ifdef IFU_MISALIGN_CHK_EN
    , .o_misalign(a_mis)
`endif
  );

  ifu_fetch #(.FIFO_DEPTH(4)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_redir_valid(redir_v), .i_redir_pc(redir_pc),
    .o_imem_req(b_req), .o_imem_addr(b_addr), .i_imem_gnt(b_gnt),
    .i_imem_rvalid(b_rv), .i_imem_rdata(mem_rd),
    .o_ins_valid(b_val), .o_ins(b_ins), .o_ins_pc(b_pc), .i_ins_ready(ready)
`ifdef IFU_MISALIGN_CHK_EN
    , .o_misalign(b_mis)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state and stimulus requests.
  int          lat = 1;
  int          cyc = 0;
  int          ngrant = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] xlog_pc[$];
  logic [31:0] xlog_ins[$];
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] exp_fetch = RST_PC;
  logic        exp_flush = 1'b0;
  logic        exp_mis = 1'b0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_addr = '0;
  logic        redir_now = 1'b0;
  logic        redir_cond = 1'b0;
  logic [31:0] redir_tgt = '0;
  logic        fire;

  function automatic logic [31:0] xpc(input int idx);
    return (idx < xlog_pc.size()) ? xlog_pc[idx] : 32'hDEAD_BEEF;
  endfunction

  // Memory model plus compare process; everything is decided at the negedge
  // for the coming posedge.
  always @(negedge clk) begin
    if (rst) begin
      q_addr.delete(); q_due.delete();
      mem_rv = 1'b0; mem_rd = '0; redir_v = 1'b0; redir_pc = '0;
      exp_pc = RST_PC; exp_fetch = RST_PC; exp_flush = 1'b0; exp_mis = 1'b0;
      hold_pend = 1'b0; ngrant = 0; cyc = 0;
    end else begin
      cyc++;
      mem_rv = 1'b0;
      if (q_addr.size() != 0 && q_due[0] <= cyc) begin
        mem_rv = 1'b1;
        mem_rd = q_addr[0] ^ KEY;
        q_addr.delete(0);
        q_due.delete(0);
      end
      if (exp_flush) begin
        chk("flush_valid", w_val, 1'b0);
        if (!exp_mis) chk("redir_addr", w_addr, exp_fetch);
      end
      if (hold_pend) chk("hold_addr", w_addr, hold_addr);
`ifdef IFU_MISALIGN_CHK_EN
      chk("misalign", w_mis, exp_mis);
      if (exp_mis) chk("halt_req", w_req, 1'b0);
`endif
      fire = 1'b0;
      if (redir_now) begin
        fire = 1'b1; redir_now = 1'b0;
      end else if (redir_cond && w_req && gnt_en && mem_rv && w_val && ready) begin
        fire = 1'b1; redir_cond = 1'b0;
      end
      redir_v  = fire;
      redir_pc = redir_tgt;
      if (w_val && ready) begin
        chk("ins_pc", w_pc, exp_pc);
        chk("ins_word", w_ins, exp_pc ^ KEY);
        xlog_pc.push_back(w_pc);
        xlog_ins.push_back(w_ins);
        exp_pc += 32'd4;
      end
      if (w_req && gnt_en) begin
        chk("fetch_addr", w_addr, exp_fetch);
        q_addr.push_back(w_addr);
        q_due.push_back(cyc + lat);
        exp_fetch += 32'd4;
        ngrant++;
      end
      hold_pend = w_req && !gnt_en && !fire;
      hold_addr = w_addr;
      exp_flush = fire;
      if (fire) begin
        exp_pc    = {redir_tgt[31:2], 2'b00};
        exp_fetch = {redir_tgt[31:2], 2'b00};
`ifdef IFU_MISALIGN_CHK_EN
        exp_mis   = (redir_tgt[1:0] != 2'b00);
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Asserts reset mid-operation, checks the asynchronous reset values, and
  // releases reset two cycles later.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_req", w_req, 1'b0);
    chk("rst_valid", w_val, 1'b0);
    chk("rst_ins", w_ins, 32'h0);
    chk("rst_ins_pc", w_pc, 32'h0);
    chk("rst_addr", w_addr, RST_PC);
`ifdef IFU_MISALIGN_CHK_EN
    chk("rst_misalign", w_mis, 1'b0);
`endif
    tick(2);
    rst = 1'b0;
    xlog_pc.delete();
    xlog_ins.delete();
  endtask

  initial begin
    int cnt0;
    tick(1);

    // 1: streaming after reset
    sel = 1'b0; lat = 1; ready = 1'b1; gnt_en = 1'b1;
    do_reset();
    @(negedge clk); #1;
    chk("t1_boot_req", w_req, 1'b0);
    @(negedge clk); #1;
    chk("t1_first_req", w_req, 1'b1);
    chk("t1_first_addr", w_addr, RST_PC);
    tick(30);
    chk("t1_pc0", xpc(0), 32'h8000_0000);
    chk("t1_pc1", xpc(1), 32'h8000_0004);
    chk("t1_ins0", (xlog_ins.size() > 0) ? xlog_ins[0] : 32'h0, 32'h25A5_A5A5);
    chk("t1_progress", (xlog_pc.size() >= 10) ? 32'd1 : 32'd0, 32'd1);

    // 2: decode stalled, buffer fills to FIFO_DEPTH, then drains in order
    ready = 1'b0;
    do_reset();
    tick(10);
    chk("t2_req_off", w_req, 1'b0);
    chk("t2_valid", w_val, 1'b1);
    chk("t2_head_pc", w_pc, 32'h8000_0000);
    chk("t2_head_ins", w_ins, 32'h25A5_A5A5);
    chk("t2_grants", ngrant, 32'd2);
    ready = 1'b1;
    tick(30);
    chk("t2_pc0", xpc(0), 32'h8000_0000);
    chk("t2_pc1", xpc(1), 32'h8000_0004);
    chk("t2_pc2", xpc(2), 32'h8000_0008);

    // 3: redirect with two requests in flight
    lat = 3;
    do_reset();
    for (int i = 0; i < 20 && ngrant < 2; i++) tick(1);
    chk("t3_two_grants", ngrant, 32'd2);
    redir_tgt = 32'h8000_0100;
    redir_now = 1'b1;
    tick(30);
    chk("t3_pc0", xpc(0), 32'h8000_0100);
    chk("t3_pc1", xpc(1), 32'h8000_0104);

    // 4: redirect coinciding with grant, rvalid and a decode transfer
    sel = 1'b1; lat = 1;
    do_reset();
    redir_tgt  = 32'h8000_0300;
    redir_cond = 1'b1;
    tick(40);
    chk("t4_fired", redir_cond, 1'b0);
    redir_cond = 1'b0;
    chk("t4_pc0", xpc(0), 32'h8000_0000);
    chk("t4_pc1", xpc(1), 32'h8000_0300);
    cnt0 = 0;
    foreach (xlog_pc[i]) if (xlog_pc[i] == RST_PC) cnt0++;
    chk("t4_once", cnt0, 32'd1);

    // 5: grant held low, address stays put
    sel = 1'b0; gnt_en = 1'b0;
    do_reset();
    tick(1);
    for (int i = 0; i < 5; i++) begin
      chk("t5_req", w_req, 1'b1);
      chk("t5_addr", w_addr, RST_PC);
      chk("t5_valid", w_val, 1'b0);
      tick(1);
    end
    gnt_en = 1'b1;
    tick(20);
    chk("t5_pc0", xpc(0), RST_PC);

`ifdef IFU_MISALIGN_CHK_EN
    // 6: misaligned redirect halts, aligned redirect resumes
    do_reset();
    tick(10);
    redir_tgt = 32'h8000_0102;
    redir_now = 1'b1;
    tick(2);
    xlog_pc.delete();
    chk("t6_mis_set", w_mis, 1'b1);
    chk("t6_req_off", w_req, 1'b0);
    tick(8);
    chk("t6_req_halt", w_req, 1'b0);
    chk("t6_valid_halt", w_val, 1'b0);
    chk("t6_no_xfer", xlog_pc.size(), 32'd0);
    redir_tgt = 32'h8000_0200;
    redir_now = 1'b1;
    tick(2);
    chk("t6_mis_clr", w_mis, 1'b0);
    tick(20);
    chk("t6_pc0", xpc(0), 32'h8000_0200);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Multi-cycle instruction fetch stage. Replaces the combinational PC-to-instruction path in front of the decoder.
- Issues word fetches to instruction memory over a req/gnt request channel. Responses return on an rvalid channel, in order and without back-pressure.
- Buffers returned words and hands {instruction, pc} to the decode stage over a valid/ready handshake.
- Accepts redirects (branch/jump/trap target) from the PC unit and discards wrong-path responses.

Parameters:
- ADDR_W, 32, PC/address width; matches CPU_WIDTH.
- RST_PC, 32'h8000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of 2, >=2.
- MAX_OST, 2, maximum outstanding granted-but-unanswered requests; >=1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_redir_valid  in  1  redirect strobe from the PC unit.
- i_redir_pc  in  ADDR_W  redirect target.
- o_imem_req  out  1  fetch request.
- o_imem_addr  out  ADDR_W  fetch address, registered.
- i_imem_gnt  in  1  request accepted when o_imem_req & i_imem_gnt.
- i_imem_rvalid  in  1  response valid; cannot be stalled.
- i_imem_rdata  in  32  response word.
- o_ins_valid  out  1  instruction available to decode.
- o_ins  out  32  instruction word.
- o_ins_pc  out  ADDR_W  PC of o_ins.
- i_ins_ready  in  1  decode accepts; transfer when o_ins_valid & i_ins_ready.
- o_misalign  out  1  misaligned redirect flag; present only with IFU_MISALIGN_CHK_EN.

Behaviour:
- Reset values:
  - fetch pc = RST_PC; o_imem_addr = RST_PC.
  - o_imem_req = 0, o_ins_valid = 0, o_ins = 0, o_ins_pc = 0, o_misalign = 0.
  - FIFO empty; outstanding count ost = 0; drop count = 0.
  - FSM = S_BOOT.
- FSM states:
  - S_BOOT: one cycle after reset release, req = 0; then S_FETCH.
  - S_FETCH: o_imem_req = (ost < MAX_OST) && (ost + fifo_count < FIFO_DEPTH). The credit rule guarantees every response has a FIFO slot.
  - S_HALT: optional feature only; o_imem_req = 0.
- Request acceptance (req & gnt):
  - fetch pc += 4, wraps modulo 2^ADDR_W.
  - ost += 1.
  - Issued pc pushed into an internal MAX_OST-deep tag queue.
  - While req & !gnt, o_imem_addr is held stable unless a redirect occurs.
- Response (rvalid):
  - ost -= 1; pop the tag queue.
  - If drop > 0: drop -= 1, word discarded.
  - Otherwise push {rdata, tag pc} into the FIFO.
  - Latency: rvalid at cycle n gives o_ins_valid at n+1 (registered FIFO, no bypass).
  - Minimum grant-to-decode latency is 2 cycles.
- Ost bookkeeping: simultaneous grant and rvalid in one cycle leaves ost unchanged.
- Output channel:
  - o_ins_valid = FIFO non-empty; o_ins/o_ins_pc show the head entry.
  - Head is held stable while valid & !ready.
  - FIFO full with ready low: no requests issue (credit), no data is lost.
- Redirect (i_redir_valid = 1), same-cycle effects:
  - A decode transfer in this cycle completes normally.
  - All remaining FIFO entries are flushed, so o_ins_valid = 0 the next cycle.
  - Any rvalid in this cycle is discarded.
  - A grant in this cycle counts as old-path.
  - drop = ost + grant - rvalid, i.e. all still-outstanding requests become wrong-path.
  - fetch pc and o_imem_addr load i_redir_pc next cycle.
  - Redirect takes priority over sequential increment.
- Back-to-back redirects: the second redirect accumulates the drop count correctly; the last target wins.
- rvalid with ost == 0 is a protocol error: ignored in RTL, flagged by a sim assertion.
- Reset asserted mid-operation: all state returns to reset values asynchronously. In-flight responses after release are the memory model's responsibility; the bench resets both.

Optional Feature:
- Macro: IFU_MISALIGN_CHK_EN.
- With the macro defined:
  - A redirect with i_redir_pc[1:0] != 0 sets o_misalign (sticky) and enters S_HALT.
  - No further requests issue; outstanding responses are still drained and dropped.
  - The next aligned redirect clears o_misalign and returns to S_FETCH.
- Without the macro:
  - The o_misalign port is absent.
  - Address bits [1:0] are forced to 0 on redirect.
  - S_HALT is unreachable and removed.

Test Plan:
1. Reset release, gnt = 1, memory returns rdata = addr ^ 32'hA5A5_A5A5 one cycle after grant, ready = 1 -> first request addr 0x8000_0000 in the cycle after S_BOOT; o_ins_pc sequence 0x8000_0000, 0x8000_0004, ... with matching o_ins.
2. ready = 0 for 10 cycles -> exactly FIFO_DEPTH (2) entries buffered; o_imem_req = 0; head held at pc 0x8000_0000; after ready = 1, no word lost or duplicated.
3. Two requests outstanding, redirect to 0x8000_0100 -> both returning responses dropped; next delivered o_ins_pc = 0x8000_0100; no stale pc ever shown.
4. Redirect in the same cycle as rvalid, grant and an output transfer -> the transferred instruction is counted once; the rvalid word is discarded; the granted request is dropped later; fetch resumes at the target.
5. gnt held low 5 cycles with req = 1 -> o_imem_addr stable; ost stays 0; o_ins_valid = 0.
6. IFU_MISALIGN_CHK_EN: redirect to 0x8000_0102 -> o_misalign = 1, req = 0; then redirect to 0x8000_0200 -> o_misalign = 0 and fetching resumes at 0x8000_0200.
